// File: rtl/maxpool_layer_2d.sv
// maxpool_layer_2d: streaming 2x2, stride-2 signed max-pool over a raster-order frame.
// Window phase is implied by the parity of the row/column counters.
module maxpool_layer_2d #(
  parameter int unsigned IN_WIDTH   = 28,
  parameter int unsigned IN_HEIGHT  = 28,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out,
  input  logic                  ready_out
);

  localparam int unsigned OUT_W = IN_WIDTH / 2;
  localparam int unsigned COL_W = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned ROW_W = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {CAPTURE, STORE, EMIT} phase_t;

  phase_t                phase;
  logic [COL_W-1:0]      col_cnt, col_nxt;
  logic [ROW_W-1:0]      row_cnt, row_nxt;
  logic                  valid_nxt, last_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [DATA_WIDTH-1:0] pair_reg;
  logic [DATA_WIDTH-1:0] line_buf [OUT_W];
  logic [IDX_W-1:0]      buf_idx;
  logic                  accept, end_col, end_row;
  logic [DATA_WIDTH-1:0] hmax, vmax;

  // State register: counters and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      col_cnt   <= col_nxt;
      row_cnt   <= row_nxt;
      valid_out <= valid_nxt;
      data_out  <= data_nxt;
      last_out  <= last_nxt;
    end
  end

  // Window storage is always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && phase == CAPTURE) pair_reg <= data_in;
    if (accept && phase == STORE)   line_buf[buf_idx] <= hmax;
  end

  // Next-state: advance raster position and load the output stage.
  always_comb begin
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    valid_nxt = valid_out;
    data_nxt  = data_out;
    last_nxt  = last_out;
    if (accept) begin
      if (end_col) begin
        col_nxt = '0;
        row_nxt = end_row ? '0 : row_cnt + ROW_W'(1);
      end else begin
        col_nxt = col_cnt + COL_W'(1);
      end
    end
    if (accept && phase == EMIT) begin
      valid_nxt = 1'b1;
      data_nxt  = vmax;
      last_nxt  = end_col && end_row;
    end else if (ready_out) begin
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
    end
  end

  // Phase decode, handshake and the two signed compare stages.
  always_comb begin
    phase    = CAPTURE;
    ready_in = 1'b0;
    accept   = 1'b0;
    if (col_cnt[0]) phase = row_cnt[0] ? EMIT : STORE;
    ready_in = !valid_out || ready_out;
    accept   = valid_in && ready_in;
    end_col  = (col_cnt == COL_W'(IN_WIDTH - 1));
    end_row  = (row_cnt == ROW_W'(IN_HEIGHT - 1));
    buf_idx  = IDX_W'(col_cnt >> 1);
    hmax     = ($signed(data_in) > $signed(pair_reg)) ? data_in : pair_reg;
    vmax     = ($signed(line_buf[buf_idx]) > $signed(hmax)) ? line_buf[buf_idx] : hmax;
  end

endmodule

// File: tb/tb_maxpool_layer_2d.sv
// tb_maxpool_layer_2d: drives a 4x4 and a 28x28 instance from shared stimulus and
// checks every output transfer against a frame-level max-pool model.
module tb_maxpool_layer_2d;

  typedef logic signed [15:0] pix_t;
  typedef pix_t pix_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_out;
  logic [15:0] data_in;
  logic        ri_s, vo_s, lo_s, ri_b, vo_b, lo_b;
  logic [15:0] do_s, do_b;
  bit          sel;
  logic        ri_m, vo_m, lo_m;
  logic signed [15:0] do_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  maxpool_layer_2d #(.IN_WIDTH(4), .IN_HEIGHT(4), .DATA_WIDTH(16)) u_small (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready_in(ri_s),
    .valid_out(vo_s), .data_out(do_s), .last_out(lo_s), .ready_out(ready_out));

  maxpool_layer_2d #(.IN_WIDTH(28), .IN_HEIGHT(28), .DATA_WIDTH(16)) u_big (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready_in(ri_b),
    .valid_out(vo_b), .data_out(do_b), .last_out(lo_b), .ready_out(ready_out));

  assign ri_m = sel ? ri_b : ri_s;
  assign vo_m = sel ? vo_b : vo_s;
  assign lo_m = sel ? lo_b : lo_s;
  assign do_m = sel ? do_b : do_s;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Streams pix through the selected instance; bp_len stalls ready_out at the first output.
  task automatic run_stream(input pix_q_t pix, input int w, input int h,
                            input bit rnd, input int bp_len);
    int exp_d[$];
    bit exp_l[$];
    int nf, idx, acc, cyc, bp_left, n_last, pos, base, m;
    bit exp_vo, emit, in_x, out_x, stall;
    nf = pix.size() / (w * h);
    for (int f = 0; f < nf; f++)
      for (int r2 = 0; r2 < h / 2; r2++)
        for (int c2 = 0; c2 < w / 2; c2++) begin
          base = f * w * h + 2 * r2 * w + 2 * c2;
          m = int'(pix[base]);
          if (int'(pix[base + 1]) > m)     m = int'(pix[base + 1]);
          if (int'(pix[base + w]) > m)     m = int'(pix[base + w]);
          if (int'(pix[base + w + 1]) > m) m = int'(pix[base + w + 1]);
          exp_d.push_back(m);
          exp_l.push_back((r2 == h / 2 - 1) && (c2 == w / 2 - 1));
        end
    idx = 0; acc = 0; cyc = 0; bp_left = bp_len; n_last = 0; exp_vo = 1'b0;
    while ((idx < pix.size() || exp_vo) && cyc < 20000) begin
      @(negedge clk);
      check("valid_out", int'(vo_m), int'(exp_vo));
      stall = vo_m && (bp_left > 0);
      if (stall) begin
        ready_out = 1'b0;
        bp_left--;
      end else begin
        ready_out = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
      valid_in = (idx < pix.size()) && (!rnd || $urandom_range(0, 9) < 7);
      data_in  = valid_in ? pix[idx] : 16'($urandom);
      #1;
      check("ready_in", int'(ri_m), int'(!exp_vo || ready_out));
      if (stall && exp_d.size() > 0) check("stall_data", int'(do_m), exp_d[0]);
      out_x = vo_m && ready_out;
      in_x  = valid_in && ri_m;
      if (out_x) begin
        if (exp_d.size() == 0) begin
          check("extra_out", int'(do_m), -99999);
        end else begin
          check("data_out", int'(do_m), exp_d.pop_front());
          check("last_out", int'(lo_m), int'(exp_l.pop_front()));
        end
        if (lo_m) n_last++;
      end
      emit = 1'b0;
      if (in_x) begin
        pos  = acc % (w * h);
        emit = ((pos / w) % 2 == 1) && ((pos % w) % 2 == 1);
        acc++;
        idx++;
      end
      exp_vo = (in_x && emit) || (exp_vo && !ready_out);
      cyc++;
    end
    check("timeout", int'(cyc >= 20000), 0);
    check("missing_out", exp_d.size(), 0);
    check("last_count", n_last, nf);
    valid_in  = 1'b0;
    ready_out = 1'b1;
  endtask

  initial begin
    pix_q_t q;
    sel = 1'b0; rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_vo_s", int'(vo_s), 0);
    check("rst_do_s", int'(do_s), 0);
    check("rst_lo_s", int'(lo_s), 0);
    check("rst_ri_s", int'(ri_s), 1);
    check("rst_vo_b", int'(vo_b), 0);
    check("rst_ri_b", int'(ri_b), 1);
    @(negedge clk) rst = 1'b0;

    // Ramp 0..15: 5, 7, 13, 15.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'(i));
    run_stream(q, 4, 4, 1'b0, 0);

    // Signed extremes in the first two windows.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'($urandom));
    q[0] = -16'sd3;  q[1] = -16'sd8;       q[4] = -16'sd1;  q[5] = 16'sh8000;
    q[2] = 16'sd32767; q[3] = 16'sh8000;   q[6] = 16'sd0;   q[7] = 16'sd0;
    run_stream(q, 4, 4, 1'b0, 0);

    // Five-cycle backpressure on the first pending output.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'(i));
    run_stream(q, 4, 4, 1'b0, 5);

    // Two frames back to back.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'(i));
    for (int i = 0; i < 16; i++) q.push_back(16'(100 + i));
    run_stream(q, 4, 4, 1'b0, 0);

    // Reset after six accepted pixels drops the pending output.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = 16'(i);
    end
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    check("pre_rst_vo", int'(vo_s), 1);
    check("pre_rst_do", int'(do_s), 5);
    rst = 1'b1;
    #1;
    check("mid_rst_vo", int'(vo_s), 0);
    check("mid_rst_ri", int'(ri_s), 1);
    @(negedge clk) rst = 1'b0;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'(i));
    run_stream(q, 4, 4, 1'b0, 0);

    // 28x28 random frame with random gaps and backpressure.
    @(negedge clk);
    rst = 1'b1;
    sel = 1'b1;
    @(negedge clk) rst = 1'b0;
    q = {};
    for (int i = 0; i < 28 * 28; i++) q.push_back(16'($urandom));
    run_stream(q, 28, 28, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
